// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word
// requests, drops stale responses after redirects and feeds the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [7:0]  Op
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [31:0]   r_tag [DEPTH];
    logic [AW-1:0] r_tag_wp;
    logic [AW-1:0] r_tag_rp;
    logic [31:0]   r_fi [DEPTH];
    logic [31:0]   r_fp [DEPTH];
    logic [AW-1:0] r_f_wp;
    logic [AW-1:0] r_f_rp;
    logic [CW-1:0] r_fcnt;
    logic          r_if_valid;
    logic [31:0]   r_if_instr;
    logic [31:0]   r_if_pc;

    logic [CW:0]   w_sum;
    logic          w_fire;
    logic          w_resp;
    logic          w_drop_now;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redir_pc;
    logic [31:0]   w_tag_pc;

    assign w_sum      = {1'b0, r_fcnt} + {1'b0, r_out};
    assign w_redir_pc = redirect_pc & ~32'd3;
    assign w_tag_pc   = r_tag[r_tag_rp];

    // A request needs a free credit: buffered plus in-flight below DEPTH.
    assign imem_req_valid = !reset && !redirect_valid
                            && (w_sum < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;

    assign w_fire     = imem_req_valid && imem_req_ready;
    assign w_resp     = imem_resp_valid && (r_out != '0);
    assign w_drop_now = w_resp && (r_drop != '0);
    assign w_push     = w_resp && (r_drop == '0) && !redirect_valid;
    assign w_pop      = !redirect_valid && !stall && (r_fcnt != '0);

    assign if_id_valid    = r_if_valid;
    assign if_id_instr    = r_if_instr;
    assign if_id_pc       = r_if_pc;
    assign if_id_pc_plus4 = r_if_pc + 32'd4;
    assign Op             = r_if_instr[31:24];

    // Fetch PC, in-flight count, drop count and tag queue pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_tag_wp   <= '0;
            r_tag_rp   <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_out      <= r_out - CW'(w_resp);
            r_drop     <= r_out - CW'(w_resp);
            r_tag_rp   <= r_tag_rp + AW'(w_resp);
        end else begin
            if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_tag_wp   <= r_tag_wp + AW'(1);
            end
            r_out    <= r_out + CW'(w_fire) - CW'(w_resp);
            r_tag_rp <= r_tag_rp + AW'(w_resp);
            if (w_drop_now)
                r_drop <= r_drop - CW'(1);
        end
    end

    // Prefetch buffer pointers and occupancy; a redirect empties it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_f_wp <= '0;
            r_f_rp <= '0;
            r_fcnt <= '0;
        end else if (redirect_valid) begin
            r_f_wp <= '0;
            r_f_rp <= '0;
            r_fcnt <= '0;
        end else begin
            r_f_wp <= r_f_wp + AW'(w_push);
            r_f_rp <= r_f_rp + AW'(w_pop);
            r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // IF/ID register: redirect kills, stall holds, otherwise load or bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else if (redirect_valid) begin
            r_if_valid <= 1'b0;
        end else if (!stall) begin
            r_if_valid <= w_pop;
            if (w_pop) begin
                r_if_instr <= r_fi[r_f_rp];
                r_if_pc    <= r_fp[r_f_rp];
            end
        end
    end

    // Storage for request tags and buffered {instr, pc} entries.
    always_ff @(posedge clock) begin
        if (w_fire)
            r_tag[r_tag_wp] <= imem_req_addr;
        if (w_push) begin
            r_fi[r_f_wp] <= imem_resp_data;
            r_fp[r_f_wp] <= w_tag_pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order latency memory model
// and a PC-sequence scoreboard on the IF/ID register.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [7:0]  Op;

    int          n_chk;
    int          n_err;
    int          cyc;
    int          lat;
    bit          chk_credit;
    bit          st_prev;
    int          n_fire;
    int          n_load;
    logic [31:0] exp_pc;
    logic [31:0] mw;
    logic [31:0] pq_addr[$];
    int          pq_t[$];
    logic [31:0] fire_log[$];

    fetch_stage #(
        .RESET_PC(RST_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .Op             (Op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[9:2] ^ 8'hC3, a[31:10], 2'b01};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model and IF/ID scoreboard, evaluated mid-cycle.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pq_addr.delete();
                pq_t.delete();
                imem_resp_valid = 1'b0;
                exp_pc  = RST_PC;
                n_fire  = 0;
                n_load  = 0;
                st_prev = 1'b1;
            end else begin
                if (if_id_valid && !st_prev) begin
                    mw = mem_word(exp_pc);
                    check("if_pc", if_id_pc, exp_pc);
                    check("if_instr", if_id_instr, mw);
                    check("if_pc4", if_id_pc_plus4, exp_pc + 32'd4);
                    check("op", {24'd0, Op}, {24'd0, mw[31:24]});
                    exp_pc = exp_pc + 32'd4;
                    n_load++;
                end
                if (redirect_valid)
                    exp_pc = redirect_pc & ~32'd3;
                if (pq_t.size() > 0 && pq_t[0] + lat <= cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pq_addr[0]);
                    void'(pq_addr.pop_front());
                    void'(pq_t.pop_front());
                end else begin
                    imem_resp_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    pq_addr.push_back(imem_req_addr);
                    pq_t.push_back(cyc);
                    fire_log.push_back(imem_req_addr);
                    n_fire++;
                end
                if (chk_credit)
                    check("credit", 32'(n_fire - n_load <= DEPTH), 32'd1);
                st_prev = stall;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            mid();
            if (if_id_valid) ok = 1'b1;
        end
        if (!ok) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold_pc;
        logic [31:0] exp_a;
        int          idx;
        bit          ok;
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        lat   = 1;
        chk_credit     = 1'b0;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_v", 32'(imem_req_valid), 32'd0);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_pc", if_id_pc, 32'd0);
        check("rst_pc4", if_id_pc_plus4, 32'd4);
        check("rst_op", {24'd0, Op}, 32'd0);

        reset = 1'b0;
        mid();
        check("first_req_v", 32'(imem_req_valid), 32'd1);
        check("first_req_a", imem_req_addr, RST_PC);
        mid();
        check("lat_c1", 32'(if_id_valid), 32'd0);
        mid();
        check("lat_c2", 32'(if_id_valid), 32'd0);
        mid();
        check("lat_c3_v", 32'(if_id_valid), 32'd1);
        check("lat_c3_pc", if_id_pc, RST_PC);
        repeat (8) mid();

        // stall for 5 cycles on a valid instruction
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (if_id_valid) ok = 1'b1;
        end
        if (!ok) check("stall_find", 32'd0, 32'd1);
        hold_pc    = exp_pc;
        stall      = 1'b1;
        chk_credit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("stall_v", 32'(if_id_valid), 32'd1);
            check("stall_pc", if_id_pc, hold_pc);
        end
        tick();
        stall      = 1'b0;
        chk_credit = 1'b0;
        repeat (8) mid();

        // redirect with two words in flight on a 3-cycle memory
        lat = 3;
        repeat (8) mid();
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (pq_t.size() == 2) ok = 1'b1;
        end
        if (!ok) check("rd_find", 32'd0, 32'd1);
        idx = fire_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        mid();
        check("rd_noreq", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        mid();
        check("rd_kill", 32'(if_id_valid), 32'd0);
        check("rd_addr", imem_req_addr, 32'h0000_2000);
        wait_valid("rd_tmo");
        check("rd_pc", if_id_pc, 32'h0000_2000);
        if (fire_log.size() > idx)
            check("rd_fire", fire_log[idx], 32'h0000_2000);
        else
            check("rd_fire_none", 32'd0, 32'd1);
        repeat (6) mid();

        // redirect together with stall and a returning response
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (pq_t.size() == 2 && pq_t[0] + lat <= cyc) ok = 1'b1;
        end
        if (!ok) check("rs_find", 32'd0, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        stall          = 1'b1;
        mid();
        check("rs_resp", 32'(imem_resp_valid), 32'd1);
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        mid();
        check("rs_kill", 32'(if_id_valid), 32'd0);
        wait_valid("rs_tmo");
        check("rs_pc", if_id_pc, 32'h0000_3000);
        repeat (6) mid();

        // memory not ready for 4 cycles
        lat = 1;
        repeat (6) mid();
        tick();
        exp_a = fire_log[fire_log.size()-1] + 32'd4;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("nr_addr", imem_req_addr, exp_a);
        end
        check("nr_bubble", 32'(if_id_valid), 32'd0);
        tick();
        imem_req_ready = 1'b1;
        repeat (6) mid();

        // fetch address wrap
        tick();
        idx = fire_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            mid();
            if (if_id_valid && if_id_pc == 32'hFFFF_FFFC) ok = 1'b1;
        end
        if (!ok) check("wrap_tmo", 32'd0, 32'd1);
        else check("wrap_pc4", if_id_pc_plus4, 32'd0);
        repeat (6) mid();
        if (fire_log.size() >= idx + 3) begin
            check("wrap_a0", fire_log[idx], 32'hFFFF_FFF8);
            check("wrap_a1", fire_log[idx+1], 32'hFFFF_FFFC);
            check("wrap_a2", fire_log[idx+2], 32'h0000_0000);
        end else begin
            check("wrap_fires", 32'd0, 32'd1);
        end

        // asynchronous reset mid-operation
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("mr_req_v", 32'(imem_req_valid), 32'd0);
        check("mr_valid", 32'(if_id_valid), 32'd0);
        check("mr_instr", if_id_instr, 32'd0);
        check("mr_pc4", if_id_pc_plus4, 32'd4);
        tick();
        reset = 1'b0;
        mid();
        check("mr_req_a", imem_req_addr, RST_PC);
        check("mr_req_v2", 32'(imem_req_valid), 32'd1);
        wait_valid("mr_tmo");
        check("mr_pc", if_id_pc, RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
